// File: rtl/drag_tree_sequencer.sv
// Drag-race christmas-tree sequencer: dark stage, amber countdown (sequential or pro),
// green launch, per-lane foul detection and millisecond reaction-time capture.
module drag_tree_sequencer #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int LANES     = 2,
  parameter int NUM_AMBER = 3,
  parameter int STAGE_MS  = 1000,
  parameter int AMBER_MS  = 500
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   En,
  input  logic                   ProMode,
  input  logic [LANES-1:0]       Launch,
  output logic [NUM_AMBER-1:0]   Amber,
  output logic [LANES-1:0]       G,
  output logic [LANES-1:0]       R,
  output logic [16*LANES-1:0]    Rt,
  output logic [LANES-1:0]       RtValid,
  output logic                   Done
);

  localparam int          CYC        = CLK_HZ / 1000;
  localparam int          PRE_W      = (CYC > 1) ? $clog2(CYC) : 1;
  localparam logic [31:0] STAGE_LAST = 32'(STAGE_MS - 1);
  localparam logic [31:0] AMBER_LAST = 32'(AMBER_MS - 1);
  localparam logic [31:0] RT_MAX     = 32'h0000_FFFF;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_STAGE = 2'd1,
    S_AMBER = 2'd2,
    S_GREEN = 2'd3
  } state_t;

  state_t           state_r;
  logic [PRE_W-1:0] pre_r;
  logic [31:0]      ms_r;
  logic             pro_r;
  logic             tick_s;
  logic [LANES-1:0] foul_s;
  logic [LANES-1:0] hit_s;
  logic             done_s;

  // Millisecond tick, per-lane foul/capture qualification and race-complete flag.
  always_comb begin
    tick_s = (pre_r == PRE_W'(CYC - 1));
    if ((state_r == S_STAGE) || (state_r == S_AMBER)) begin
      foul_s = Launch;
    end else begin
      foul_s = {LANES{1'b0}};
    end
    if (state_r == S_GREEN) begin
      hit_s = Launch & ~R & ~RtValid;
    end else begin
      hit_s = {LANES{1'b0}};
    end
    if (state_r == S_IDLE) begin
      done_s = 1'b0;
    end else begin
      done_s = &(R | RtValid);
    end
  end

  assign Done = done_s;

  // Race sequencer: ms_r counts whole ms within STAGE/AMBER and doubles as the reaction timer in GREEN.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_r <= S_IDLE;
      pre_r   <= {PRE_W{1'b0}};
      ms_r    <= 32'd0;
      pro_r   <= 1'b0;
      Amber   <= {NUM_AMBER{1'b0}};
      G       <= {LANES{1'b0}};
      R       <= {LANES{1'b0}};
      Rt      <= {(16*LANES){1'b0}};
      RtValid <= {LANES{1'b0}};
    end else begin
      R <= R | foul_s;
      for (int i = 0; i < LANES; i++) begin
        if (hit_s[i]) begin
          Rt[16*i +: 16] <= ms_r[15:0];
          RtValid[i]     <= 1'b1;
        end
      end
      pre_r <= tick_s ? {PRE_W{1'b0}} : pre_r + PRE_W'(1);

      case (state_r)
        S_IDLE: begin
          pre_r <= {PRE_W{1'b0}};
          ms_r  <= 32'd0;
          Amber <= {NUM_AMBER{1'b0}};
          G     <= {LANES{1'b0}};
          if (En) begin
            state_r <= S_STAGE;
            pro_r   <= ProMode;
            R       <= {LANES{1'b0}};
            Rt      <= {(16*LANES){1'b0}};
            RtValid <= {LANES{1'b0}};
          end
        end

        S_STAGE: begin
          if (!En) begin
            state_r <= S_IDLE;
            ms_r    <= 32'd0;
            Amber   <= {NUM_AMBER{1'b0}};
            G       <= {LANES{1'b0}};
          end else if (tick_s) begin
            if (ms_r == STAGE_LAST) begin
              state_r <= S_AMBER;
              ms_r    <= 32'd0;
              Amber   <= pro_r ? {NUM_AMBER{1'b1}} : NUM_AMBER'(1);
            end else begin
              ms_r <= ms_r + 32'd1;
            end
          end
        end

        S_AMBER: begin
          if (!En) begin
            state_r <= S_IDLE;
            ms_r    <= 32'd0;
            Amber   <= {NUM_AMBER{1'b0}};
            G       <= {LANES{1'b0}};
          end else if (tick_s) begin
            if (ms_r == AMBER_LAST) begin
              ms_r <= 32'd0;
              // A launch in this final amber cycle is a foul, so it must already mask green.
              if (pro_r || Amber[NUM_AMBER-1]) begin
                state_r <= S_GREEN;
                Amber   <= {NUM_AMBER{1'b0}};
                G       <= ~(R | foul_s);
              end else begin
                Amber <= Amber << 1;
              end
            end else begin
              ms_r <= ms_r + 32'd1;
            end
          end
        end

        S_GREEN: begin
          if (!En) begin
            state_r <= S_IDLE;
            ms_r    <= 32'd0;
            Amber   <= {NUM_AMBER{1'b0}};
            G       <= {LANES{1'b0}};
          end else if (tick_s && (ms_r < RT_MAX)) begin
            ms_r <= ms_r + 32'd1;
          end
        end

        default: begin
          state_r <= S_IDLE;
          ms_r    <= 32'd0;
          Amber   <= {NUM_AMBER{1'b0}};
          G       <= {LANES{1'b0}};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_drag_tree_sequencer.sv
// Bench for drag_tree_sequencer: timeline model checked every cycle plus literal
// checkpoints; a second 1-cycle-per-ms instance exercises reaction-time saturation.
module tb_drag_tree_sequencer;

  localparam int CYC  = 4;
  localparam int ST_C = 2 * CYC;
  localparam int AM_C = 1 * CYC;
  localparam int NA   = 3;

  logic        Clock;
  logic        Reset, En, ProMode;
  logic [1:0]  Launch;
  logic [2:0]  Amber;
  logic [1:0]  G, R, RtValid;
  logic [31:0] Rt;
  logic        Done;

  logic        reset2, en2, pro2;
  logic [1:0]  launch2;
  logic [2:0]  amber2;
  logic [1:0]  g2, r2, rtv2;
  logic [31:0] rt2;
  logic        done2;

  int n_cmp = 0;
  int n_bad = 0;
  bit sat_done = 1'b0;

  drag_tree_sequencer #(.CLK_HZ(4000), .LANES(2), .NUM_AMBER(3), .STAGE_MS(2), .AMBER_MS(1)) dut (
    .Clock(Clock), .Reset(Reset), .En(En), .ProMode(ProMode), .Launch(Launch),
    .Amber(Amber), .G(G), .R(R), .Rt(Rt), .RtValid(RtValid), .Done(Done)
  );

  drag_tree_sequencer #(.CLK_HZ(1000), .LANES(2), .NUM_AMBER(3), .STAGE_MS(1), .AMBER_MS(1)) dut_sat (
    .Clock(Clock), .Reset(reset2), .En(en2), .ProMode(pro2), .Launch(launch2),
    .Amber(amber2), .G(g2), .R(r2), .Rt(rt2), .RtValid(rtv2), .Done(done2)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  // Race model: the race is a timeline measured in cycles since stage entry.
  bit       m_run = 1'b0;
  bit       m_pro = 1'b0;
  int       m_t   = 0;
  bit [1:0] m_r   = 2'b00;
  bit [1:0] m_rtv = 2'b00;
  int       m_rt[2] = '{0, 0};

  function automatic int green_start();
    return ST_C + AM_C * (m_pro ? 1 : NA);
  endfunction

  initial begin
    forever begin
      @(posedge Clock or posedge Reset);
      if (Reset) begin
        m_run = 1'b0; m_t = 0; m_pro = 1'b0; m_r = 2'b00; m_rtv = 2'b00;
        m_rt[0] = 0; m_rt[1] = 0;
      end else if (!m_run) begin
        if (En) begin
          m_run = 1'b1; m_t = 0; m_pro = ProMode; m_r = 2'b00; m_rtv = 2'b00;
          m_rt[0] = 0; m_rt[1] = 0;
        end
      end else begin
        if (m_t < green_start()) begin
          m_r = m_r | Launch;
        end else begin
          for (int i = 0; i < 2; i++) begin
            if (Launch[i] && !m_r[i] && !m_rtv[i]) begin
              m_rt[i]  = ((m_t - green_start()) / CYC > 65535) ? 65535 : (m_t - green_start()) / CYC;
              m_rtv[i] = 1'b1;
            end
          end
        end
        if (!En) m_run = 1'b0;
        else     m_t++;
      end
    end
  end

  // Every-cycle comparison of the main instance against the model.
  initial begin
    forever begin
      @(negedge Clock);
      begin
        automatic logic [2:0]  e_amber = 3'b000;
        automatic logic [1:0]  e_g     = 2'b00;
        automatic logic        e_done;
        automatic logic [31:0] e_rt;
        automatic logic [31:0] rt1 = 32'(m_rt[1]);
        automatic logic [31:0] rt0 = 32'(m_rt[0]);
        if (m_run && (m_t >= ST_C)) begin
          if (m_t < green_start()) e_amber = m_pro ? 3'b111 : 3'(1 << ((m_t - ST_C) / AM_C));
          else                     e_g = ~m_r;
        end
        e_done = m_run && ((m_r | m_rtv) == 2'b11);
        e_rt   = {rt1[15:0], rt0[15:0]};
        chk("amber",   64'(Amber),   64'(e_amber));
        chk("green",   64'(G),       64'(e_g));
        chk("red",     64'(R),       64'(m_r));
        chk("rt",      64'(Rt),      64'(e_rt));
        chk("rtvalid", 64'(RtValid), 64'(m_rtv));
        chk("done",    64'(Done),    64'(e_done));
      end
    end
  end

  // Saturation run on the fast-tick instance: green begins 4 cycles after stage entry.
  initial begin
    reset2 = 1'b1; en2 = 1'b0; pro2 = 1'b0; launch2 = 2'b00;
    tick(2);
    reset2 = 1'b0;
    en2    = 1'b1;
    tick(1);
    tick(65545);
    chk("sat_green", 64'(g2), 64'(2'b11));
    launch2 = 2'b11;
    tick(1);
    chk("sat_rt",      64'(rt2),   64'(32'hFFFF_FFFF));
    chk("sat_rtvalid", 64'(rtv2),  64'(2'b11));
    chk("sat_done",    64'(done2), 64'(1'b1));
    en2 = 1'b0; launch2 = 2'b00;
    tick(1);
    sat_done = 1'b1;
  end

  // Directed races on the main instance.
  initial begin
    Reset = 1'b1; En = 1'b0; ProMode = 1'b0; Launch = 2'b00;
    tick(2);
    chk("rst_amber", 64'(Amber), 64'(3'b000));
    chk("rst_g",     64'(G),     64'(2'b00));
    chk("rst_rt",    64'(Rt),    64'(32'h0));
    chk("rst_done",  64'(Done),  64'(1'b0));
    Reset = 1'b0;

    // Sequential race, both lanes launch 5 cycles into green -> 1 ms.
    En = 1'b1;
    tick(1);  chk("seq_t0_dark", 64'(Amber), 64'(3'b000));
    tick(7);  chk("seq_t7_dark", 64'(Amber), 64'(3'b000));
    tick(1);  chk("seq_a0", 64'(Amber), 64'(3'b001));
    tick(4);  chk("seq_a1", 64'(Amber), 64'(3'b010));
    tick(4);  chk("seq_a2", 64'(Amber), 64'(3'b100));
    tick(4);  chk("seq_green", 64'(G), 64'(2'b11));
    tick(5);  Launch = 2'b11;
    tick(1);
    chk("seq_rt",   64'(Rt),      64'({16'd1, 16'd1}));
    chk("seq_rtv",  64'(RtValid), 64'(2'b11));
    chk("seq_done", 64'(Done),    64'(1'b1));
    En = 1'b0; Launch = 2'b00;
    tick(1);
    chk("end_g",      64'(G),       64'(2'b00));
    chk("end_rtv",    64'(RtValid), 64'(2'b11));
    chk("end_done",   64'(Done),    64'(1'b0));

    // Pro race: lane 0 fouls in the final amber cycle, lane 1 already launching at green entry.
    En = 1'b1; ProMode = 1'b1;
    tick(1);
    tick(8);  chk("pro_amber", 64'(Amber), 64'(3'b111));
    ProMode = 1'b0;
    tick(3);  Launch = 2'b01;
    tick(1);
    chk("pro_foul_r", 64'(R),     64'(2'b01));
    chk("pro_g",      64'(G),     64'(2'b10));
    chk("pro_amber0", 64'(Amber), 64'(3'b000));
    Launch = 2'b10;
    tick(1);
    chk("pro_rt",   64'(Rt),      64'(32'h0));
    chk("pro_rtv",  64'(RtValid), 64'(2'b10));
    chk("pro_done", 64'(Done),    64'(1'b1));
    En = 1'b0; Launch = 2'b00;
    tick(1);

    // Foul on lane 1 during amber step 1, lane 0 launches 12 cycles after green.
    En = 1'b1;
    tick(1);  chk("foul_r_clear", 64'(R), 64'(2'b00));
    tick(12); chk("foul_a1", 64'(Amber), 64'(3'b010));
    Launch = 2'b10;
    tick(1);  chk("foul_r", 64'(R), 64'(2'b10));
    Launch = 2'b00;
    tick(7);  chk("foul_g", 64'(G), 64'(2'b01));
    tick(12); Launch = 2'b01;
    tick(1);
    chk("foul_rt",   64'(Rt),      64'({16'd0, 16'd3}));
    chk("foul_rtv",  64'(RtValid), 64'(2'b01));
    chk("foul_done", 64'(Done),    64'(1'b1));
    Launch = 2'b11;
    tick(4);  chk("foul_rt_hold", 64'(Rt), 64'({16'd0, 16'd3}));
    Launch = 2'b00;

    // Aborts in STAGE and AMBER.
    En = 1'b0;
    tick(1);
    En = 1'b1;
    tick(1);  chk("restart_rtv", 64'(RtValid), 64'(2'b00));
    tick(3);  En = 1'b0;
    tick(1);  chk("abort_stage_g", 64'(G), 64'(2'b00));
    En = 1'b1;
    tick(11); chk("abort_pre_amber", 64'(Amber), 64'(3'b001));
    En = 1'b0;
    tick(1);  chk("abort_amber", 64'(Amber), 64'(3'b000));

    // Reset pulse in green, then restart.
    En = 1'b1;
    tick(21); chk("rst_race_g", 64'(G), 64'(2'b11));
    Launch = 2'b01;
    tick(1);  chk("rst_race_rtv", 64'(RtValid), 64'(2'b01));
    Launch = 2'b00;
    Reset = 1'b1;
    #1;
    chk("async_g",   64'(G),       64'(2'b00));
    chk("async_rtv", 64'(RtValid), 64'(2'b00));
    chk("async_r",   64'(R),       64'(2'b00));
    tick(1);
    Reset = 1'b0;
    tick(1);
    tick(8);  chk("post_rst_a0", 64'(Amber), 64'(3'b001));
    En = 1'b0;
    tick(1);

    for (int k = 0; (k < 70000) && !sat_done; k++) @(posedge Clock);
    chk("sat_finished", 64'(sat_done), 64'(1'b1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/drag_tree_sequencer.md
DRAG_TREE_SEQUENCER -- requirements
Module: drag_tree_sequencer

Interface
REQ-001 SHALL provide parameter CLK_HZ, 50_000_000, input clock frequency in Hz; must be a multiple of 1000.
REQ-002 SHALL provide parameter LANES, 2, number of racing lanes (1..8).
REQ-003 SHALL provide parameter NUM_AMBER, 3, number of amber lamps (1..8).
REQ-004 SHALL provide parameter STAGE_MS, 1000, dark stage delay before the first amber, in ms (>=1).
REQ-005 SHALL provide parameter AMBER_MS, 500, duration of each amber step, in ms (>=1).
REQ-006 SHALL provide ports, one per line:
- Clock  input  1  single system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- En  input  1  run enable, level-sensitive; high runs a race, low aborts or ends it.
- ProMode  input  1  0 = sequential tree, 1 = pro tree; sampled on the IDLE->STAGE transition only.
- Launch  input  LANES  per-lane launch beam; high = vehicle has left the stage.
- Amber  output  NUM_AMBER  amber lamps, bit 0 lit first.
- G  output  LANES  per-lane green lamp.
- R  output  LANES  per-lane red (foul) lamp.
- Rt  output  16*LANES  per-lane reaction time in ms; lane i at bits [16i+15:16i].
- RtValid  output  LANES  per-lane reaction-time-captured flag.
- Done  output  1  high when every lane is fouled or has RtValid set.

Function
REQ-007 SHALL derive a 1 ms tick by counting CLK_HZ/1000 Clock cycles; the tick prescaler is cleared on IDLE->STAGE so all phases align to whole ms.
REQ-008 SHALL implement states IDLE, STAGE, AMBER, GREEN.
REQ-009 IDLE: Amber=0 and G=0; with En=1, next cycle -> STAGE, clear R, Rt, RtValid, latch ProMode.
REQ-010 STAGE: all lamps dark for exactly STAGE_MS*CLK_HZ/1000 cycles, then -> AMBER at step 0.
REQ-011 AMBER, sequential mode: step k lights only Amber[k] for AMBER_MS*CLK_HZ/1000 cycles; after step NUM_AMBER-1 -> GREEN.
REQ-012 AMBER, pro mode: all Amber bits lit together for one AMBER_MS interval, then -> GREEN.
REQ-013 GREEN: Amber=0; G[i]=1 for every lane with R[i]=0; remain in GREEN while En=1.
REQ-014 Foul: Launch[i]=1 on any cycle in STAGE or AMBER SHALL set R[i] on the next edge; R[i] stays set until the next IDLE->STAGE transition.
REQ-015 A fouled lane SHALL never assert G[i] or RtValid[i] in that race; other lanes are unaffected.
REQ-016 Reaction: on GREEN entry the per-lane ms counter is 0 and increments on each ms tick, saturating at 16'hFFFF.
REQ-017 On the first cycle in GREEN with Launch[i]=1 and R[i]=0 and RtValid[i]=0, Rt[i] SHALL capture the counter value and RtValid[i] SHALL set; later Launch activity is ignored.
REQ-018 Launch[i] already high at GREEN entry SHALL capture Rt[i]=0 (no foul, since it was not high during STAGE/AMBER).
REQ-019 Done = AND over lanes of (R[i] | RtValid[i]), combinational from registered state, low in IDLE.
REQ-020 En=0 in any non-IDLE state SHALL return to IDLE next edge, extinguishing Amber and G; R, Rt, RtValid retain their values.
REQ-021 Simultaneous Launch in the last AMBER cycle and transition to GREEN SHALL count as a foul.

Reset
REQ-022 Reset=1 SHALL asynchronously force IDLE, prescaler and counters to 0, Amber=0, G=0, R=0, Rt=0, RtValid=0.
REQ-023 Reset asserted mid-race SHALL abort immediately; after release, a new race starts only if En=1 (IDLE->STAGE next edge).

Verification (CLK_HZ=4000, LANES=2, NUM_AMBER=3, STAGE_MS=2, AMBER_MS=1; 1 ms = 4 cycles)
REQ-024 Sequential race: En=1 at cycle 0, Launch=0 -> dark 8 cycles, Amber 001/010/100 for 4 cycles each, then G=2'b11.
REQ-025 Pro race: ProMode=1 -> after 8 dark cycles Amber=3'b111 for 4 cycles, then G=2'b11.
REQ-026 Foul: Launch[1]=1 during Amber=3'b010 -> R=2'b10 next cycle; at GREEN G=2'b01; Launch[0] 12 cycles after GREEN -> Rt[0]=3, RtValid=2'b01, Done=1.
REQ-027 Saturation: Launch held 0 for >65535 ms in GREEN, then Launch=2'b11 -> Rt=16'hFFFF per lane, RtValid=2'b11.
REQ-028 Abort/reset: En=0 during STAGE -> IDLE next edge, all lamps off; Reset pulse in GREEN -> all outputs 0 immediately; En=1 after release restarts at STAGE.
